// File: rtl/wishbone_classic_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic device among NUM_CTRL controllers,
// with a per-transfer wait-state watchdog that aborts a stalled strobe with an error.
module wishbone_classic_arbiter #(
  parameter int NUM_CTRL  = 4,
  parameter int DAT_WIDTH = 8,
  parameter int ADR_WIDTH = 16,
  parameter int TIMEOUT   = 16,
  localparam int SEL_WIDTH = DAT_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CTRL-1:0]           c_cyc_i,
  input  logic [NUM_CTRL-1:0]           c_stb_i,
  input  logic [NUM_CTRL-1:0]           c_we_i,
  input  logic [NUM_CTRL*ADR_WIDTH-1:0] c_adr_i,
  input  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i,
  input  logic [NUM_CTRL*SEL_WIDTH-1:0] c_sel_i,
  output logic [NUM_CTRL-1:0]           c_ack_o,
  output logic [NUM_CTRL-1:0]           c_err_o,
  output logic [NUM_CTRL-1:0]           c_rty_o,
  output logic [DAT_WIDTH-1:0]          c_dat_o,
  output logic                          d_cyc_o,
  output logic                          d_stb_o,
  output logic                          d_we_o,
  output logic [ADR_WIDTH-1:0]          d_adr_o,
  output logic [DAT_WIDTH-1:0]          d_dat_o,
  output logic [SEL_WIDTH-1:0]          d_sel_o,
  input  logic                          d_ack_i,
  input  logic                          d_err_i,
  input  logic                          d_rty_i,
  input  logic [DAT_WIDTH-1:0]          d_dat_i,
  output logic [NUM_CTRL-1:0]           grant_o
);

  localparam int IDX_W = $clog2(NUM_CTRL);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [IDX_W-1:0]     gnt;
  logic [IDX_W-1:0]     last;
  logic [IDX_W-1:0]     pick;
  logic [NUM_CTRL-1:0]  pick_oh;
  logic [CNT_W-1:0]     cnt;

  logic                 own_cyc;
  logic                 own_stb_in;
  logic                 own_we;
  logic [ADR_WIDTH-1:0] own_adr;
  logic [DAT_WIDTH-1:0] own_dat;
  logic [SEL_WIDTH-1:0] own_sel;

  logic busy;
  logic own_stb;
  logic d_resp;
  logic abort;

  // First requester strictly after lst, wrapping; scanning downward leaves the nearest one.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CTRL-1:0] req,
                                                input logic [IDX_W-1:0]    lst);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    int               idx;
    sel = lst;
    for (int i = NUM_CTRL; i >= 1; i--) begin
      idx  = (int'(lst) + i) % NUM_CTRL;
      cand = IDX_W'(idx);
      if (req[cand]) sel = cand;
    end
    return sel;
  endfunction

  always_comb begin
    own_cyc    = 1'b0;
    own_stb_in = 1'b0;
    own_we     = 1'b0;
    own_adr    = '0;
    own_dat    = '0;
    own_sel    = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (gnt == IDX_W'(k)) begin
        own_cyc    = c_cyc_i[k];
        own_stb_in = c_stb_i[k];
        own_we     = c_we_i[k];
        own_adr    = c_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
        own_dat    = c_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
        own_sel    = c_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  assign busy    = (state == BUSY);
  assign own_stb = busy & own_cyc & own_stb_in;
  assign d_resp  = d_ack_i | d_err_i | d_rty_i;
  // A real device response on the limit cycle wins over the watchdog.
  assign abort   = (TIMEOUT > 0) && own_stb && !d_resp && (cnt == CNT_W'(TIMEOUT));
  assign pick    = rr_pick(c_cyc_i, last);
  assign pick_oh = NUM_CTRL'(1) << pick;

  assign d_cyc_o = busy & own_cyc & ~abort;
  assign d_stb_o = own_stb & ~abort;
  assign d_we_o  = busy & own_we;
  assign d_adr_o = busy ? own_adr : '0;
  assign d_dat_o = busy ? own_dat : '0;
  assign d_sel_o = busy ? own_sel : '0;
  assign c_dat_o = d_dat_i;

  assign c_ack_o = {NUM_CTRL{own_stb & d_ack_i}} & grant_o;
  assign c_err_o = {NUM_CTRL{own_stb & ~d_ack_i & (d_err_i | abort)}} & grant_o;
  assign c_rty_o = {NUM_CTRL{own_stb & ~d_ack_i & ~d_err_i & d_rty_i}} & grant_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      gnt     <= '0;
      last    <= IDX_W'(NUM_CTRL - 1);
      cnt     <= '0;
      grant_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (|c_cyc_i) begin
            gnt     <= pick;
            grant_o <= pick_oh;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!own_cyc) begin
            last    <= gnt;
            grant_o <= '0;
            cnt     <= '0;
            state   <= IDLE;
          end else if ((TIMEOUT > 0) && own_stb && !d_resp && !abort) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_classic_arbiter.sv
// Bench for wishbone_classic_arbiter: vector table, directed corner sequences and a
// randomized run compared against a transaction-level reference model.
module tb_wishbone_classic_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic [N-1:0]    c_cyc_i = '0, c_stb_i = '0, c_we_i = '0;
  logic [N*AW-1:0] c_adr_i = '0;
  logic [N*DW-1:0] c_dat_i = '0;
  logic [N*SW-1:0] c_sel_i = '0;
  logic [N-1:0]    c_ack_o, c_err_o, c_rty_o, grant_o;
  logic [DW-1:0]   c_dat_o, d_dat_o;
  logic            d_cyc_o, d_stb_o, d_we_o;
  logic [AW-1:0]   d_adr_o;
  logic [SW-1:0]   d_sel_o;
  logic            d_ack_i = 1'b0, d_err_i = 1'b0, d_rty_i = 1'b0;
  logic [DW-1:0]   d_dat_i = '0;

  wishbone_classic_arbiter #(.NUM_CTRL(N), .DAT_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .c_cyc_i(c_cyc_i), .c_stb_i(c_stb_i), .c_we_i(c_we_i),
    .c_adr_i(c_adr_i), .c_dat_i(c_dat_i), .c_sel_i(c_sel_i),
    .c_ack_o(c_ack_o), .c_err_o(c_err_o), .c_rty_o(c_rty_o), .c_dat_o(c_dat_o),
    .d_cyc_o(d_cyc_o), .d_stb_o(d_stb_o), .d_we_o(d_we_o),
    .d_adr_o(d_adr_o), .d_dat_o(d_dat_o), .d_sel_o(d_sel_o),
    .d_ack_i(d_ack_i), .d_err_i(d_err_i), .d_rty_i(d_rty_i), .d_dat_i(d_dat_i),
    .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [N-1:0]  cyc;
    logic [N-1:0]  stb;
    logic          dack;
    logic [N-1:0]  exp_grant;
    logic          exp_dcyc;
    logic [AW-1:0] exp_adr;
    logic [N-1:0]  exp_ack;
  } vec_t;

  vec_t tv[6];

  // Reference model state: owner -1 means nobody holds the bus.
  int          m_owner, m_prev, m_waits;
  logic        m_st, m_resp, m_to;
  logic [N-1:0] eg, eack, eerr, erty;
  logic        edcyc, edstb, edwe;
  logic [AW-1:0] eadr;
  logic [DW-1:0] edat;
  logic [SW-1:0] esel;
  logic        grant_ok, resp_ok;
  int          rpct, spct;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic cyc_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] one;
    one = 1;
    return one << k;
  endfunction

  task automatic clear_inputs();
    c_cyc_i = '0; c_stb_i = '0; c_we_i = '0;
    d_ack_i = 1'b0; d_err_i = 1'b0; d_rty_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b0;
    cyc_edge();
    rst_i = 1'b1;
  endtask

  task automatic run_timeout(input bit late);
    clear_inputs();
    c_cyc_i = 4'b0010; c_stb_i = 4'b0010;
    settle();
    chk("to idle grant", grant_o, 4'b0000);
    cyc_edge();
    for (int w = 1; w <= 18; w++) begin
      d_ack_i = late && (w == 17);
      settle();
      chk("to grant", grant_o, 4'b0010);
      if (w == 17 && !late) begin
        chk("to abort dcyc", d_cyc_o, 1'b0);
        chk("to abort err", c_err_o, 4'b0010);
        chk("to abort ack", c_ack_o, 4'b0000);
      end else if (w == 17) begin
        chk("late dcyc", d_cyc_o, 1'b1);
        chk("late err", c_err_o, 4'b0000);
        chk("late ack", c_ack_o, 4'b0010);
      end else begin
        chk("to wait dcyc", d_cyc_o, 1'b1);
        chk("to wait err", c_err_o, 4'b0000);
        chk("to wait ack", c_ack_o, 4'b0000);
      end
      cyc_edge();
    end
    clear_inputs();
    settle();
    chk("to release dcyc", d_cyc_o, 1'b0);
    cyc_edge();
  endtask

  initial begin
    tv[0] = '{cyc:4'b0100, stb:4'b0100, dack:1'b0, exp_grant:4'b0000, exp_dcyc:1'b0, exp_adr:16'h0000, exp_ack:4'b0000};
    tv[1] = '{cyc:4'b0100, stb:4'b0100, dack:1'b0, exp_grant:4'b0100, exp_dcyc:1'b1, exp_adr:16'h1234, exp_ack:4'b0000};
    tv[2] = '{cyc:4'b0100, stb:4'b0100, dack:1'b0, exp_grant:4'b0100, exp_dcyc:1'b1, exp_adr:16'h1234, exp_ack:4'b0000};
    tv[3] = '{cyc:4'b0100, stb:4'b0100, dack:1'b1, exp_grant:4'b0100, exp_dcyc:1'b1, exp_adr:16'h1234, exp_ack:4'b0100};
    tv[4] = '{cyc:4'b0000, stb:4'b0000, dack:1'b0, exp_grant:4'b0100, exp_dcyc:1'b0, exp_adr:16'h1234, exp_ack:4'b0000};
    tv[5] = '{cyc:4'b0000, stb:4'b0000, dack:1'b1, exp_grant:4'b0000, exp_dcyc:1'b0, exp_adr:16'h0000, exp_ack:4'b0000};

    // Reset state with requests and a device ack present.
    c_cyc_i = 4'b1111; c_stb_i = 4'b1111; d_ack_i = 1'b1; d_dat_i = 8'h5A;
    settle();
    chk("rst grant", grant_o, 4'b0000);
    chk("rst dev", {d_cyc_o, d_stb_o, d_we_o, d_adr_o, d_dat_o, d_sel_o}, '0);
    chk("rst resp", {c_ack_o, c_err_o, c_rty_o}, '0);
    chk("rst cdat", c_dat_o, 8'h5A);
    cyc_edge();
    settle();
    chk("rst held grant", grant_o, 4'b0000);
    cyc_edge();
    clear_inputs();
    rst_i = 1'b1;

    // Single transfer vector table.
    for (int k = 0; k < N; k++) c_adr_i[k*AW +: AW] = 16'hA000 + 16'(k);
    c_adr_i[2*AW +: AW] = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      c_cyc_i = tv[i].cyc; c_stb_i = tv[i].stb; d_ack_i = tv[i].dack;
      settle();
      chk("tv grant", grant_o, tv[i].exp_grant);
      chk("tv dcyc", {d_cyc_o, d_stb_o}, {tv[i].exp_dcyc, tv[i].exp_dcyc});
      chk("tv adr", d_adr_o, tv[i].exp_adr);
      chk("tv ack", c_ack_o, tv[i].exp_ack);
      cyc_edge();
    end

    run_timeout(1'b0);
    run_timeout(1'b1);

    // Round-robin with all controllers requesting.
    do_reset();
    c_cyc_i = 4'b1111; c_stb_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("rr idle grant", grant_o, 4'b0000);
      cyc_edge();
      d_ack_i = 1'b1;
      settle();
      chk("rr grant", grant_o, oh(i % N));
      chk("rr ack", c_ack_o, oh(i % N));
      cyc_edge();
      d_ack_i = 1'b0;
      c_cyc_i[i % N] = 1'b0; c_stb_i[i % N] = 1'b0;
      settle();
      chk("rr release dcyc", d_cyc_o, 1'b0);
      cyc_edge();
      c_cyc_i[i % N] = 1'b1; c_stb_i[i % N] = 1'b1;
    end
    clear_inputs();
    cyc_edge();
    cyc_edge();

    // Asynchronous reset in the middle of a wait.
    c_cyc_i = 4'b1000; c_stb_i = 4'b1000;
    settle();
    chk("rm idle grant", grant_o, 4'b0000);
    cyc_edge();
    settle();
    chk("rm busy grant", grant_o, 4'b1000);
    chk("rm busy dcyc", d_cyc_o, 1'b1);
    d_ack_i = 1'b1;
    rst_i = 1'b0;
    #1;
    chk("rm async dcyc", d_cyc_o, 1'b0);
    chk("rm async grant", grant_o, 4'b0000);
    chk("rm async ack", c_ack_o, 4'b0000);
    cyc_edge();
    c_cyc_i = 4'b1001; c_stb_i = 4'b1001; d_ack_i = 1'b0;
    settle();
    chk("rm held grant", grant_o, 4'b0000);
    rst_i = 1'b1;
    cyc_edge();
    settle();
    chk("rm prio grant", grant_o, 4'b0001);
    cyc_edge();
    clear_inputs();
    cyc_edge();

    // Randomized traffic against the reference model.
    do_reset();
    m_owner = -1; m_prev = N - 1; m_waits = 0;
    for (int i = 0; i < 2000; i++) begin
      rpct = ((i / 250) % 2 == 1) ? 3 : 40;
      spct = ((i / 250) % 2 == 1) ? 100 : 75;
      for (int k = 0; k < N; k++) begin
        if (c_cyc_i[k]) begin
          if ($urandom_range(0, 11) == 0) begin
            c_cyc_i[k] = 1'b0; c_stb_i[k] = 1'b0;
          end else begin
            c_stb_i[k] = ($urandom_range(0, 99) < spct);
          end
        end else if ($urandom_range(0, 4) == 0) begin
          c_cyc_i[k] = 1'b1; c_stb_i[k] = 1'b1;
        end
        c_we_i[k] = 1'($urandom);
        c_adr_i[k*AW +: AW] = 16'($urandom);
        c_dat_i[k*DW +: DW] = 8'($urandom);
        c_sel_i[k*SW +: SW] = SW'($urandom);
      end
      d_ack_i = 1'b0; d_err_i = 1'b0; d_rty_i = 1'b0;
      if ($urandom_range(0, 99) < rpct) begin
        case ($urandom_range(0, 2))
          0: d_ack_i = 1'b1;
          1: d_err_i = 1'b1;
          default: d_rty_i = 1'b1;
        endcase
      end
      d_dat_i = 8'($urandom);
      settle();

      eg = '0; eack = '0; eerr = '0; erty = '0;
      edcyc = 1'b0; edstb = 1'b0; edwe = 1'b0; eadr = '0; edat = '0; esel = '0;
      m_st = 1'b0; m_to = 1'b0;
      m_resp = d_ack_i | d_err_i | d_rty_i;
      if (m_owner >= 0) begin
        eg    = oh(m_owner);
        m_st  = c_cyc_i[m_owner] & c_stb_i[m_owner];
        m_to  = (m_waits == TO) && m_st && !m_resp;
        edcyc = c_cyc_i[m_owner] && !m_to;
        edstb = m_st && !m_to;
        edwe  = c_we_i[m_owner];
        eadr  = c_adr_i[m_owner*AW +: AW];
        edat  = c_dat_i[m_owner*DW +: DW];
        esel  = c_sel_i[m_owner*SW +: SW];
        eack  = (m_st && d_ack_i) ? eg : '0;
        eerr  = (m_st && (d_err_i || m_to)) ? eg : '0;
        erty  = (m_st && d_rty_i) ? eg : '0;
      end
      chk("rnd grant", grant_o, eg);
      chk("rnd dev", {d_cyc_o, d_stb_o, d_we_o, d_adr_o, d_dat_o, d_sel_o},
          {edcyc, edstb, edwe, eadr, edat, esel});
      chk("rnd resp", {c_ack_o, c_err_o, c_rty_o}, {eack, eerr, erty});
      chk("rnd cdat", c_dat_o, d_dat_i);
      grant_ok = ($countones(grant_o) <= 1);
      resp_ok  = ($countones({c_ack_o, c_err_o, c_rty_o}) <= 1) &&
                 (((c_ack_o | c_err_o | c_rty_o) & ~grant_o) == '0);
      chk("props", {grant_ok, resp_ok}, 2'b11);

      if (m_owner < 0) begin
        for (int j = 1; j <= N; j++) begin
          if (m_owner < 0 && c_cyc_i[(m_prev + j) % N]) m_owner = (m_prev + j) % N;
        end
      end else if (!c_cyc_i[m_owner]) begin
        m_prev = m_owner; m_owner = -1; m_waits = 0;
      end else if (m_st && !m_resp && !m_to) begin
        m_waits++;
      end else begin
        m_waits = 0;
      end
      cyc_edge();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
